ifu_pc_ctrl: RTL and testbench

- Instruction-fetch controller that sequences the 4096-word instruction ROM (text base 0x0000_3000, byte-addressed, word-aligned).
- Holds the PC register and selects the next PC: sequential, conditional branch, J/JAL, or JR.
- Applies stall and traps illegal fetch addresses.
- Sits between the decode/branch logic and the ROM. Drives `pc` to the ROM and returns a gated instruction word plus a fetch-valid strobe.

---
 rtl/ifu_pc_ctrl.sv | 129 ++++++++++++
 tb/tb_ifu_pc_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ifu_pc_ctrl.sv
// ifu_pc_ctrl: instruction-fetch PC controller for the text ROM.
// Holds the PC and selects the next PC from four sources: sequential,
// conditional branch, J/JAL or JR. It also applies stall and traps
// illegal fetch addresses.
//
// Optional macro IFU_DELAY_SLOT_EN: MIPS branch-delay-slot semantics.
// A redirect is parked in a pending register and takes effect one issued
// instruction later.
//
// Ports:
//   clk, reset   - clock; synchronous active-high reset
//   stall        - hold PC, counter and pending redirect; redirects ignored
//   br_taken     - branch taken;  br_offset = signed word offset
//   j_en         - J/JAL;         j_index   = 26-bit index field
//   jr_en        - JR;            jr_target = register target
//   ins_in       - ROM word at pc
//   pc           - fetch address to the ROM
//   ins_out      - ins_in when fetch_valid, else NOP (0)
//   fetch_valid  - instruction at pc issued this cycle
//   fault        - sticky illegal-fetch flag
//   fault_addr   - illegal next-PC value that caused the fault
//   fetch_cnt    - number of issued instructions
module ifu_pc_ctrl #(
    parameter logic [31:0] TEXT_BASE  = 32'h0000_3000,
    parameter int unsigned TEXT_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [15:0] br_offset,
    input  logic        j_en,
    input  logic [25:0] j_index,
    input  logic        jr_en,
    input  logic [31:0] jr_target,
    input  logic [31:0] ins_in,
    output logic [31:0] pc,
    output logic [31:0] ins_out,
    output logic        fetch_valid,
    output logic        fault,
    output logic [31:0] fault_addr,
    output logic [31:0] fetch_cnt
);

    localparam logic [31:0] TEXT_LAST = TEXT_BASE + 32'(4 * (TEXT_WORDS - 1));

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] seq_pc;
    logic [31:0] redirect_target;
    logic        redirect;
    logic [31:0] next_pc;
    logic        illegal;

`ifdef IFU_DELAY_SLOT_EN
    logic        pend_valid;
    logic [31:0] pend_target;
`endif

    // Redirect target selection; jr_en > j_en > br_taken.
    always_comb begin
        seq_pc          = pc + 32'd4;
        redirect        = jr_en | j_en | br_taken;
        redirect_target = seq_pc;
        if (jr_en) begin
            redirect_target = jr_target;
        end else if (j_en) begin
            redirect_target = {seq_pc[31:28], j_index, 2'b00};
        end else if (br_taken) begin
            redirect_target = seq_pc + {{14{br_offset[15]}}, br_offset, 2'b00};
        end
    end

`ifdef IFU_DELAY_SLOT_EN
    // Delay slot issues next; a parked target is taken when the slot issues.
    always_comb begin
        next_pc = pend_valid ? pend_target : seq_pc;
    end
`else
    always_comb begin
        next_pc = redirect ? redirect_target : seq_pc;
    end
`endif

    always_comb begin
        illegal = (next_pc[1:0] != 2'b00) || (next_pc < TEXT_BASE) || (next_pc > TEXT_LAST);
    end

    assign fetch_valid = (state == RUN) && !stall;
    assign ins_out     = fetch_valid ? ins_in : 32'h0;

    // PC / fault FSM; FAULT freezes everything until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            pc          <= TEXT_BASE;
            fault       <= 1'b0;
            fault_addr  <= 32'h0;
            fetch_cnt   <= 32'h0;
`ifdef IFU_DELAY_SLOT_EN
            pend_valid  <= 1'b0;
            pend_target <= 32'h0;
`endif
        end else if (state == RUN && !stall) begin
            fetch_cnt <= fetch_cnt + 32'd1;
            if (illegal) begin
                state      <= FAULT;
                fault      <= 1'b1;
                fault_addr <= next_pc;
            end else begin
                pc <= next_pc;
`ifdef IFU_DELAY_SLOT_EN
                // Redirects seen while the delay slot issues are dropped.
                if (pend_valid) begin
                    pend_valid <= 1'b0;
                end else if (redirect) begin
                    pend_valid  <= 1'b1;
                    pend_target <= redirect_target;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_ifu_pc_ctrl.sv
// Scoreboard bench for ifu_pc_ctrl: expected post-edge state is queued when
// each cycle's stimulus is driven and popped after the clock edge.
module tb_ifu_pc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        br_taken;
    logic [15:0] br_offset;
    logic        j_en;
    logic [25:0] j_index;
    logic        jr_en;
    logic [31:0] jr_target;
    logic [31:0] ins_in;
    logic [31:0] pc;
    logic [31:0] ins_out;
    logic        fetch_valid;
    logic        fault;
    logic [31:0] fault_addr;
    logic [31:0] fetch_cnt;

    typedef struct {
        logic [31:0] pc;
        logic        fault;
        logic [31:0] fault_addr;
        logic [31:0] fetch_cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_cnt  = 32'h0;

    ifu_pc_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_offset  (br_offset),
        .j_en       (j_en),
        .j_index    (j_index),
        .jr_en      (jr_en),
        .jr_target  (jr_target),
        .ins_in     (ins_in),
        .pc         (pc),
        .ins_out    (ins_out),
        .fetch_valid(fetch_valid),
        .fault      (fault),
        .fault_addr (fault_addr),
        .fetch_cnt  (fetch_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic s, input logic b, input logic [15:0] off,
                         input logic j, input logic [25:0] idx,
                         input logic jr, input logic [31:0] jrt);
        stall     = s;
        br_taken  = b;
        br_offset = off;
        j_en      = j;
        j_index   = idx;
        jr_en     = jr;
        jr_target = jrt;
        ins_in    = $urandom;
    endtask

    // Check issue outputs now, queue the expected post-edge state, clock, compare.
    task automatic step(input logic [31:0] epc, input logic ef, input logic [31:0] efa,
                        input logic ev);
        exp_t e;
        exp_t g;
        #1;
        chk("fetch_valid", 32'(fetch_valid), 32'(ev));
        chk("ins_out", ins_out, ev ? ins_in : 32'h0);
        if (ev) exp_cnt = exp_cnt + 32'd1;
        e.pc = epc; e.fault = ef; e.fault_addr = efa; e.fetch_cnt = exp_cnt;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        g = sb_q.pop_front();
        chk("pc", pc, g.pc);
        chk("fault", 32'(fault), 32'(g.fault));
        chk("fault_addr", fault_addr, g.fault_addr);
        chk("fetch_cnt", fetch_cnt, g.fetch_cnt);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b1, 16'h1, 1'b1, 26'h1, 1'b1, 32'h0000_0001);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        exp_cnt = 32'h0;
        chk("rst_pc", pc, 32'h0000_3000);
        chk("rst_fault", 32'(fault), 32'h0);
        chk("rst_fault_addr", fault_addr, 32'h0);
        chk("rst_fetch_cnt", fetch_cnt, 32'h0);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        @(posedge clk);
        #1;
        do_reset();

`ifdef IFU_DELAY_SLOT_EN
        // Branch at 0x3000 (target 0x3014); delay slot 0x3004 issues first.
        drive(1'b0, 1'b1, 16'h0004, 1'b0, 26'h0, 1'b0, 32'h0);
        step(32'h0000_3004, 1'b0, 32'h0, 1'b1);
        // Stall during the delay slot, redirects asserted and ignored.
        drive(1'b1, 1'b1, 16'h0010, 1'b1, 26'h0000C10, 1'b0, 32'h0);
        step(32'h0000_3004, 1'b0, 32'h0, 1'b0);
        // Delay slot issues; a redirect here is ignored, pending target loads.
        drive(1'b0, 1'b0, 16'h0, 1'b1, 26'h0000C10, 1'b0, 32'h0);
        step(32'h0000_3014, 1'b0, 32'h0, 1'b1);
        idle();
        step(32'h0000_3018, 1'b0, 32'h0, 1'b1);
        // Misaligned JR target: delay slot legal, then fault when target loads.
        drive(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h0000_3002);
        step(32'h0000_301C, 1'b0, 32'h0, 1'b1);
        idle();
        step(32'h0000_301C, 1'b1, 32'h0000_3002, 1'b1);
        do_reset();
`else
        // Free-running sequential fetch.
        idle();
        step(32'h0000_3004, 1'b0, 32'h0, 1'b1);
        step(32'h0000_3008, 1'b0, 32'h0, 1'b1);
        step(32'h0000_300C, 1'b0, 32'h0, 1'b1);
        // Stall two cycles with a branch asserted; nothing moves.
        drive(1'b1, 1'b1, 16'h0010, 1'b0, 26'h0, 1'b0, 32'h0);
        step(32'h0000_300C, 1'b0, 32'h0, 1'b0);
        step(32'h0000_300C, 1'b0, 32'h0, 1'b0);
        idle();
        step(32'h0000_3010, 1'b0, 32'h0, 1'b1);
        // All redirects at once: JR wins.
        drive(1'b0, 1'b1, 16'h0040, 1'b1, 26'h0000100, 1'b1, 32'h0000_3400);
        step(32'h0000_3400, 1'b0, 32'h0, 1'b1);
        // J with branch also set: J wins.
        drive(1'b0, 1'b1, 16'h0040, 1'b1, 26'h0000C10, 1'b0, 32'h0);
        step(32'h0000_3040, 1'b0, 32'h0, 1'b1);
        // JR back to 0x3008, then backward branch.
        drive(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h0000_3008);
        step(32'h0000_3008, 1'b0, 32'h0, 1'b1);
        drive(1'b0, 1'b1, 16'hFFFE, 1'b0, 26'h0, 1'b0, 32'h0);
        step(32'h0000_3004, 1'b0, 32'h0, 1'b1);
        idle();
        step(32'h0000_3008, 1'b0, 32'h0, 1'b1);
        drive(1'b0, 1'b1, 16'h0003, 1'b0, 26'h0, 1'b0, 32'h0);
        step(32'h0000_3018, 1'b0, 32'h0, 1'b1);
        // Misaligned JR: fault, pc holds, then everything frozen.
        drive(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h0000_3002);
        step(32'h0000_3018, 1'b1, 32'h0000_3002, 1'b1);
        drive(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h0000_3100);
        step(32'h0000_3018, 1'b1, 32'h0000_3002, 1'b0);
        idle();
        step(32'h0000_3018, 1'b1, 32'h0000_3002, 1'b0);
        do_reset();
        // Last legal word, then sequential fall-through off the end.
        drive(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h0000_6FFC);
        step(32'h0000_6FFC, 1'b0, 32'h0, 1'b1);
        idle();
        step(32'h0000_6FFC, 1'b1, 32'h0000_7000, 1'b1);
        step(32'h0000_6FFC, 1'b1, 32'h0000_7000, 1'b0);
        do_reset();
        // Below the text base.
        drive(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h0000_2FFC);
        step(32'h0000_3000, 1'b1, 32'h0000_2FFC, 1'b1);
        do_reset();
        idle();
        step(32'h0000_3004, 1'b0, 32'h0, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
